// File: rtl/popcount_enum.sv
// Enumerates all WIDTH-bit words with popcount k in increasing order.
// Successor per word uses Gosper's rule with the divide done as a shift.
module popcount_enum #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KW-1:0]    k,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             err
);

  localparam int TZW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW:0] WMAX = (KW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] ALL1 = '1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [WIDTH-1:0] top_q, top_nxt;
  logic [WIDTH-1:0] succ;
  logic             err_q, err_nxt;
  logic             bad, last;
  logic [WIDTH:0]   v1, c, r, x;
  logic [TZW-1:0]   tz;

  assign bad  = ({1'b0, k} > WMAX);
  assign last = (data_q == top_q);

  // Extra MSB keeps r = v + c from wrapping.
  assign v1 = {1'b0, data_q};
  assign c  = v1 & (~v1 + 1'b1);
  assign r  = v1 + c;
  assign x  = (v1 ^ r) >> 2;

  always_comb begin
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (c[i]) tz = TZW'(i);
    end
  end

  assign succ = WIDTH'(r | (x >> tz));

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    top_nxt   = top_q;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (bad) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = EMIT;
            data_nxt  = ~(ALL1 << k);
            top_nxt   = ~(ALL1 >> k);
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last) state_nxt = IDLE;
          else      data_nxt  = succ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      top_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      top_q  <= top_nxt;
      err_q  <= err_nxt;
    end
  end

  assign busy      = (state == EMIT);
  assign out_valid = busy;
  assign out_last  = busy && last;
  assign out_data  = data_q;
  assign err       = err_q;

endmodule

// File: doc/popcount_enum.md
POPCOUNT_ENUM -- requirements
Module: popcount_enum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, output word width; legal range 1..32.
REQ-002 SHALL have parameter KW, default $clog2(WIDTH+1), width of k input.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request enumeration; sampled only when idle.
REQ-006 SHALL have port k, input, KW, target popcount; sampled with accepted start.
REQ-007 SHALL have port busy, output, 1, high from accepted start until final handshake.
REQ-008 SHALL have port out_valid, output, 1, out_data valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts word.
REQ-010 SHALL have port out_data, output, WIDTH, enumerated word.
REQ-011 SHALL have port out_last, output, 1, marks final word; qualified by out_valid.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on rejected start (k > WIDTH).

Function
REQ-013 SHALL have two states, IDLE and EMIT; busy == (state == EMIT).
REQ-014 IDLE, start=1, k<=WIDTH: SHALL go to EMIT next edge, out_valid=1, out_data=(1<<k)-1.
REQ-015 IDLE, start=1, k>WIDTH: SHALL stay IDLE, err=1 for exactly the next cycle, no out_valid.
REQ-016 start while busy SHALL be ignored; k changes while busy SHALL have no effect.
REQ-017 Handshake = out_valid && out_ready at a rising edge.
REQ-018 SHALL hold out_data/out_last stable while out_valid && !out_ready.
REQ-019 On handshake of non-last word: out_valid SHALL stay 1; out_data SHALL become the next larger WIDTH-bit value with popcount k, next edge (no bubbles).
REQ-020 Successor SHALL be exact (Gosper rule: c=lowest set bit, r=v+c, next=r | (((v^r)>>2)/c)); all arithmetic in at least WIDTH+1 bits, no overflow into out_data.
REQ-021 out_last SHALL be 1 iff out_data equals k ones in the top k bits (includes k=0 -> 0, k=WIDTH -> all ones).
REQ-022 Each enumeration SHALL emit exactly C(WIDTH,k) words, strictly increasing, each with $countones(out_data)==k.
REQ-023 On handshake of last word: out_valid, out_last, busy SHALL drop next edge; state IDLE; new start accepted in that following cycle.
REQ-024 Start-to-first-valid latency SHALL be 1 cycle; sustained throughput 1 word/cycle with out_ready=1.
REQ-025 out_data SHALL retain last emitted value in IDLE; out_last=0 in IDLE.
REQ-026 Division step SHALL be realised as right shift by trailing-zero count of c; no divider instance.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force state IDLE, busy=0, out_valid=0, out_last=0, err=0, out_data=0.
REQ-028 Reset mid-enumeration SHALL abandon the sequence; after release no word emitted until a new start.
REQ-029 First start SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-030 WIDTH=4, k=2, out_ready=1 -> out_data 0011,0101,0110,1001,1010,1100 on 6 consecutive cycles, out_last only with 1100, busy low next cycle.
REQ-031 WIDTH=4, k=0 -> single word 0000 with out_last=1; k=4 -> single word 1111 with out_last=1.
REQ-032 WIDTH=4, k=5 -> err high one cycle, busy and out_valid stay 0.
REQ-033 WIDTH=8, k=3, out_ready low 3 cycles on second word 00001011 -> word held stable; total 56 handshakes, last 11100000.
REQ-034 WIDTH=8, k=4, rst_n pulsed low after 10 words -> outputs zero at once, no valid until new start; restart begins at 00001111.
REQ-035 Bench SHALL assert every handshaked word has $countones == k and exceeds previous word, for WIDTH in {1,8,32}, random k and random out_ready.
